// File: rtl/result_demux.sv
// result_demux: registered 1-to-2 demultiplexer with valid/ready handshakes.
// One producer word per cycle is steered by in_sel into one of two
// independent circular FIFOs, each draining under its own backpressure.
// Optional build macro RESULT_DEMUX_STATS_EN adds saturating per-port accept
// counters on acc0_cnt/acc1_cnt; without it both ports read constant zero.
module result_demux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [15:0]      acc0_cnt,
  output logic [15:0]      acc1_cnt
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [1:0]            ready_v;
  logic [1:0]            valid_v;
  logic [1:0]            not_full;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0][WIDTH-1:0] head;

  // in_ready looks only at registered occupancy of the selected FIFO, so a
  // same-cycle pop on a full FIFO never opens the door (no pass-through).
  assign ready_v  = {out1_ready, out0_ready};
  assign in_ready = not_full[in_sel];
  assign push[0]  = in_valid && in_ready && !in_sel;
  assign push[1]  = in_valid && in_ready &&  in_sel;
  assign pop      = valid_v & ready_v;

  for (genvar p = 0; p < 2; p++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage write; entries are not reset because a zero count masks them.
    always_ff @(posedge clk) begin
      if (push[p]) begin
        mem[wr_ptr] <= in_data;
      end
    end

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[p]) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop[p]) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push[p], pop[p]})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end

    assign valid_v[p]  = (count != '0);
    assign not_full[p] = (count < FULL_CNT);
    assign head[p]     = valid_v[p] ? mem[rd_ptr] : '0;
  end

  assign out0_valid = valid_v[0];
  assign out1_valid = valid_v[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];

`ifdef RESULT_DEMUX_STATS_EN
  logic [1:0][15:0] acc_q;

  for (genvar p = 0; p < 2; p++) begin : g_stats
    // Saturating accept counter; sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc_q[p] <= '0;
      end else if (push[p] && (acc_q[p] != 16'hFFFF)) begin
        acc_q[p] <= acc_q[p] + 16'd1;
      end
    end
  end

  assign acc0_cnt = acc_q[0];
  assign acc1_cnt = acc_q[1];
`else
  assign acc0_cnt = 16'h0;
  assign acc1_cnt = 16'h0;
`endif

endmodule

// File: doc/result_demux.md
# result_demux

Registered 1-to-2 demultiplexer with valid/ready handshakes, the distributing counterpart of the datapath 2:1 select mux. It accepts one data word per cycle from a single producer, such as the execute-stage result. Each word is routed by a per-word select bit into one of two independent output FIFOs, for example register-file writeback and store-data path. Each output drains under its own backpressure, so a stalled consumer never blocks traffic bound for the other.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 2, entries per output FIFO; power of two, ≥2
- clk  input  1  rising-edge clock; sole clock
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- in_valid  input  1  producer presents a word
- in_ready  output  1  demux can accept the word toward the FIFO chosen by in_sel
- in_sel  input  1  destination: 0 → port 0, 1 → port 1
- in_data  input  WIDTH  word
- out0_valid  output  1  port 0 FIFO non-empty
- out0_ready  input  1  port 0 consumer takes head word
- out0_data  output  WIDTH  port 0 head word
- out1_valid / out1_ready / out1_data: same as port 0, for port 1
- acc0_cnt  output  16  words accepted toward port 0 (see Configuration)
- acc1_cnt  output  16  words accepted toward port 1 (see Configuration)

## Operation
- Two identical circular FIFOs, each with:
  - wr_ptr, rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH
  - count of log2(DEPTH)+1 bits
- in_ready = (count[in_sel] < DEPTH); combinational from in_sel and registered count only, never from in_valid.
- Accept = in_valid && in_ready. On accept:
  - in_data is written at wr_ptr[in_sel]
  - wr_ptr[in_sel] increments and wraps
  - count[in_sel] increments
  - the other FIFO is untouched
- outN_valid = (countN != 0). outN_data = mem[rd_ptrN] when valid, all-zero when empty.
- Pop N = outN_valid && outN_ready. On pop, rd_ptrN increments and wraps, and countN decrements.
- Simultaneous accept and pop on the same FIFO: count is unchanged and both pointers advance. This is legal only when the FIFO is not full. A full FIFO deasserts in_ready, and a same-cycle pop does not re-enable it (no pass-through).
- in_valid with the selected FIFO full: no state change. The producer must hold in_data/in_sel stable until accepted.
- outN_ready while empty: ignored.
- Order is preserved within each port. There is no ordering guarantee between ports.
- No combinational path from in_* to out*_* and none from outN_ready to in_ready.

## Timing
- Reset (rst_n=0 at a clk edge):
  - all pointers and counts return to 0
  - out0_valid = out1_valid = 0, out0_data = out1_data = 0
  - acc0_cnt = acc1_cnt = 0
  - in_ready = 1 in the first cycle after reset
- Reset mid-operation discards all buffered words. Memory contents need not be cleared, because they are masked by the zeroed counts.
- Latency: a word accepted at edge k appears on outN_valid/outN_data after edge k, i.e. usable by the consumer at edge k+1. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained into a port whose consumer holds ready=1. Alternating in_sel sustains 1 word/cycle overall.
- Full FIFO: in_ready for that destination returns high the cycle after the pop edge.

## Configuration
- RESULT_DEMUX_STATS_EN defined:
  - acc0_cnt/acc1_cnt are 16-bit registers that increment on each accept toward the respective port
  - they saturate at 0xFFFF and do not wrap
  - they reset to 0
- Not defined: counter registers are absent and acc0_cnt = acc1_cnt = 16'h0 constantly. Port list is identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → all outputs 0 and no words emerge after release. Then in_ready=1 on the first cycle.
- Single route: accept 0xDEADBEEF with sel=0 at edge k → out0_valid=1, out0_data=0xDEADBEEF after edge k; out1_valid stays 0.
- Backpressure isolation (DEPTH=2): out0_ready=0 and send 0x1, 0x2 to port 0 → in_ready=0 for sel=0. Sel=1 words 0xA, 0xB still pass to port 1. Raise out0_ready → 0x1 then 0x2 in order.
- Wrap/concurrency: 10 words 0..9 to port 1 with out1_ready toggling pseudo-randomly → output sequence exactly 0..9, count never exceeds 2, and pointers wrap correctly.
- Mid-operation reset: port 0 holding 2 words, assert rst_n=0 for one cycle → out0_valid=0 next cycle and the old words never appear.
- Stats (macro on): 70000 accepts to port 0 → acc0_cnt=0xFFFF, acc1_cnt=0. With the macro off, both read 0.
